// File: rtl/adc_mem_reader.sv
// DPRAM read controller: streams the ADC capture region onto a valid/ready
// sample stream, absorbing the DPRAM read latency with a credit-gated FIFO.

module adc_mem_reader_chk #(
  parameter int CNT_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_fifo_cnt,
  input  logic [CNT_W-1:0] i_inflight
);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  // Entries held plus reads still in flight may never exceed the FIFO size.
  a_credit: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (({1'b0, i_fifo_cnt} + {1'b0, i_inflight}) <= DEPTH_C));

  a_fifo_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ({1'b0, i_fifo_cnt} <= DEPTH_C));
endmodule

module adc_mem_reader #(
  parameter int                   ADDR_BITS  = 13,
  parameter int                   DATA_W     = 32,
  parameter logic [ADDR_BITS-1:0] ADDR_START = 13'h400,
  parameter logic [ADDR_BITS-1:0] ADDR_SPAN  = 13'h1000,
  parameter int                   RD_LAT     = 1,
  parameter int                   FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 csr_start_i,
  input  logic                 csr_loop_i,
  input  logic                 csr_stop_i,
  output logic                 csr_busy_o,
  output logic                 csr_done_o,
  output logic                 mem_re_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  input  logic [DATA_W-1:0]    mem_data_i,
  output logic                 m_valid_o,
  output logic [DATA_W-1:0]    m_data_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i
);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_START + ADDR_SPAN - 1'b1;
  localparam int                   PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                   CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]       DEPTH_C   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_BITS:0]   SPAN_C    = {1'b0, ADDR_SPAN};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_start_q, r_stop_q;
  logic                  r_loop, r_done, r_busy;
  logic [ADDR_BITS-1:0]  r_ptr;
  logic [ADDR_BITS:0]    r_issued;
  logic [CNT_W-1:0]      r_inflight, r_fifo_cnt;
  logic [PTR_W-1:0]      r_wr_idx, r_rd_idx;
  logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [RD_LAT-1:0]     r_re_pipe, r_last_pipe;

  logic                  w_start_pulse, w_stop_pulse, w_busy_st, w_abort;
  logic [CNT_W:0]        w_used;
  logic                  w_credit, w_re, w_at_last, w_ret, w_push, w_pop, w_valid;

  function automatic logic [PTR_W-1:0] idx_inc(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(FIFO_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return idx + 1'b1;
    end
  endfunction

  assign w_start_pulse = csr_start_i & ~r_start_q;
  assign w_stop_pulse  = csr_stop_i & ~r_stop_q;
  assign w_busy_st     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_abort       = w_stop_pulse & w_busy_st;
  assign w_used        = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
  assign w_credit      = w_used < DEPTH_C;
  // The stop pulse gates the read enable combinationally so no read leaves on the abort cycle.
  assign w_re          = (r_state == ST_RUN) & ~w_stop_pulse & w_credit &
                         (r_loop | (r_issued < SPAN_C));
  assign w_at_last     = r_ptr == ADDR_LAST;
  assign w_ret         = r_re_pipe[RD_LAT-1];
  assign w_push        = w_ret & w_busy_st & ~w_abort;
  assign w_valid       = r_fifo_cnt != {CNT_W{1'b0}};
  assign w_pop         = w_valid & m_ready_i;

  assign mem_re_o   = w_re;
  assign mem_addr_o = r_ptr;
  assign m_valid_o  = w_valid;
  assign m_data_o   = r_fifo_data[r_rd_idx];
  assign m_last_o   = r_fifo_last[r_rd_idx];
  assign csr_busy_o = r_busy;
  assign csr_done_o = r_done;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_pulse) w_state_nxt = ST_RUN;
        else               w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_stop_pulse)                        w_state_nxt = ST_DONE;
        else if (w_re && w_at_last && !r_loop)   w_state_nxt = ST_DRAIN;
        else                                     w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (w_stop_pulse || (w_pop && m_last_o)) w_state_nxt = ST_DONE;
        else                                     w_state_nxt = ST_DRAIN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, CSR edge detectors and pass control (pointer, count, flags).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_loop    <= 1'b0;
      r_ptr     <= ADDR_START;
      r_issued  <= {(ADDR_BITS+1){1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= csr_start_i;
      r_stop_q  <= csr_stop_i;
      r_busy    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      case (r_state)
        ST_IDLE: begin
          if (w_start_pulse) begin
            r_done   <= 1'b0;
            r_loop   <= csr_loop_i;
            r_ptr    <= ADDR_START;
            r_issued <= {(ADDR_BITS+1){1'b0}};
          end
        end
        ST_RUN: begin
          if (w_re) begin
            if (w_at_last && r_loop) r_ptr <= ADDR_START;
            else                     r_ptr <= r_ptr + 1'b1;
            if (!r_loop) r_issued <= r_issued + 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
          r_ptr  <= ADDR_START;
        end
        default: r_ptr <= r_ptr;
      endcase
    end
  end

  // Read-return tracking: delay line matching the DPRAM latency plus in-flight count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_re_pipe   <= {RD_LAT{1'b0}};
      r_last_pipe <= {RD_LAT{1'b0}};
      r_inflight  <= {CNT_W{1'b0}};
    end else if (w_abort) begin
      r_re_pipe   <= {RD_LAT{1'b0}};
      r_last_pipe <= {RD_LAT{1'b0}};
      r_inflight  <= {CNT_W{1'b0}};
    end else begin
      r_re_pipe[0]   <= w_re;
      r_last_pipe[0] <= w_re & w_at_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_re_pipe[i]   <= r_re_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_re) - CNT_W'(w_ret);
    end
  end

  // Output FIFO; an abort empties it without touching the storage.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_idx    <= {PTR_W{1'b0}};
      r_rd_idx    <= {PTR_W{1'b0}};
      r_fifo_cnt  <= {CNT_W{1'b0}};
      r_fifo_last <= {FIFO_DEPTH{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo_data[i] <= {DATA_W{1'b0}};
    end else if (w_abort) begin
      r_wr_idx   <= {PTR_W{1'b0}};
      r_rd_idx   <= {PTR_W{1'b0}};
      r_fifo_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_idx] <= mem_data_i;
        r_fifo_last[r_wr_idx] <= r_last_pipe[RD_LAT-1];
        r_wr_idx              <= idx_inc(r_wr_idx);
      end
      if (w_pop) r_rd_idx <= idx_inc(r_rd_idx);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  adc_mem_reader_chk #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .i_clk      (sys_clk),
    .i_rst_n    (sys_rst_n),
    .i_fifo_cnt (r_fifo_cnt),
    .i_inflight (r_inflight)
  );
endmodule

// File: tb/tb_adc_mem_reader.sv
// Bench for adc_mem_reader: scenario table plus corner-case sequences, checked
// against a model where the k-th word of a pass is k mod 4096 read from 0x400+k.
module tb_adc_mem_reader;
  localparam int          SPAN  = 4096;
  localparam logic [12:0] START = 13'h400;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        csr_start_i = 1'b0, csr_loop_i = 1'b0, csr_stop_i = 1'b0;
  logic        csr_busy_o, csr_done_o, mem_re_o;
  logic [12:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        m_valid_o, m_last_o;
  logic [31:0] m_data_o;
  logic        m_ready_i = 1'b0;

  logic [31:0] dpram [8192];

  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 1'b0, oneshot = 1'b1, prev_stall = 1'b0;
  int rd_cnt = 0, hs_cnt = 0, last_hs_cyc = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  typedef struct {
    bit loop;
    int pct;
    int stop_at;
    int exp_hs;
    bit exp_done;
    bit exp_busy;
  } vec_t;
  vec_t vecs[4];

  adc_mem_reader dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .csr_start_i (csr_start_i),
    .csr_loop_i  (csr_loop_i),
    .csr_stop_i  (csr_stop_i),
    .csr_busy_o  (csr_busy_o),
    .csr_done_o  (csr_done_o),
    .mem_re_o    (mem_re_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (mem_re_o) mem_data_i <= dpram[mem_addr_o];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rnd_ready(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic model_reset(input bit os);
    rd_cnt = 0; hs_cnt = 0; oneshot = os; prev_stall = 1'b0; mon_en = 1'b1;
  endtask

  // Observes one cycle: read addresses, credit bound, stall stability, stream order.
  task automatic monitor();
    if (mon_en) begin
      if (mem_re_o) begin
        chk("rd_addr", mem_addr_o, START + (rd_cnt % SPAN));
        if (oneshot) chk("rd_extra", rd_cnt < SPAN, 1);
        rd_cnt++;
      end
      chk("credit", (rd_cnt - hs_cnt) <= 4, 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid_o, 1);
        chk("stall_data", m_data_o, prev_data);
        chk("stall_last", m_last_o, prev_last);
      end
      if (m_valid_o && m_ready_i) begin
        chk("hs_data", m_data_o, hs_cnt % SPAN);
        chk("hs_last", m_last_o, (hs_cnt % SPAN) == SPAN - 1);
        if (oneshot) chk("hs_extra", hs_cnt < SPAN, 1);
        last_hs_cyc = cyc;
        hs_cnt++;
      end
      prev_stall = m_valid_o && !m_ready_i && !csr_stop_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end else begin
      prev_stall = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    monitor();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic start_pass(input bit loop);
    model_reset(!loop);
    csr_loop_i  = loop;
    csr_start_i = 1'b1;
    tick();
    csr_start_i = 1'b0;
    csr_loop_i  = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int pct);
    for (int i = 0; i < 60000 && hs_cnt < n; i++) begin
      m_ready_i = rnd_ready(pct);
      tick();
    end
    chk("reach_hs", hs_cnt, n);
  endtask

  task automatic wait_done(input int pct);
    for (int i = 0; i < 60000 && !csr_done_o; i++) begin
      m_ready_i = rnd_ready(pct);
      tick();
    end
    chk("done_set", csr_done_o, 1);
  endtask

  task automatic do_stop();
    m_ready_i  = 1'b0;
    csr_stop_i = 1'b1;
    #2;
    chk("stop_re_gate", mem_re_o, 0);
    tick();
    csr_stop_i = 1'b0;
    chk("stop_flush", m_valid_o, 0);
    m_ready_i = 1'b1;
    tick();
    tick();
    chk("stop_done", csr_done_o, 1);
    chk("stop_busy", csr_busy_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stop_no_stale", m_valid_o, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, csr_busy_o, 0);
    chk({tag, "_done"}, csr_done_o, 0);
    chk({tag, "_re"}, mem_re_o, 0);
    chk({tag, "_addr"}, mem_addr_o, START);
    chk({tag, "_valid"}, m_valid_o, 0);
    chk({tag, "_data"}, m_data_o, 0);
    chk({tag, "_last"}, m_last_o, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 30,      0,  4096, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 100, 10000, 10000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 50,   5000,  5000, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 70,   1500,  1500, 1'b1, 1'b0};

    for (int a = 0; a < 8192; a++) dpram[a] = 32'hDEAD0000 | a;
    for (int i = 0; i < SPAN; i++) dpram[START + i] = i;

    #12;
    chk_reset_outputs("rst");
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    tick();

    // First pass: latency and done timing with ready held high.
    model_reset(1'b1);
    m_ready_i   = 1'b1;
    csr_start_i = 1'b1;
    #2;
    chk("re_before_start", mem_re_o, 0);
    tick();
    csr_start_i = 1'b0;
    #2;
    chk("first_re", mem_re_o, 1);
    chk("first_addr", mem_addr_o, START);
    chk("busy_run", csr_busy_o, 1);
    tick();
    chk("valid_early", m_valid_o, 0);
    tick();
    chk("first_valid", m_valid_o, 1);
    chk("first_data", m_data_o, 0);
    wait_done(100);
    chk("pass_hs", hs_cnt, SPAN);
    chk("pass_rd", rd_cnt, SPAN);
    chk("done_delay", cyc - last_hs_cyc, 2);
    chk("pass_busy", csr_busy_o, 0);
    repeat (3) tick();

    // Scenario table: mode, ready duty, optional stop point.
    for (int v = 0; v < 4; v++) begin
      m_ready_i = 1'b0;
      start_pass(vecs[v].loop);
      if (vecs[v].stop_at != 0) begin
        wait_hs(vecs[v].stop_at, vecs[v].pct);
        do_stop();
      end else begin
        wait_done(vecs[v].pct);
        chk("vec_rd", rd_cnt, SPAN);
      end
      chk("vec_hs", hs_cnt, vecs[v].exp_hs);
      chk("vec_done", csr_done_o, vecs[v].exp_done);
      chk("vec_busy", csr_busy_o, vecs[v].exp_busy);
      repeat (3) tick();
    end

    // Stop with the FIFO full and ready low, then replay from the start.
    m_ready_i = 1'b1;
    start_pass(1'b0);
    wait_hs(50, 100);
    m_ready_i = 1'b0;
    repeat (8) tick();
    chk("full_valid", m_valid_o, 1);
    chk("full_no_re", mem_re_o, 0);
    do_stop();
    start_pass(1'b0);
    wait_hs(300, 100);
    do_stop();

    // Start held high, then re-pulsed mid-pass: one uninterrupted pass.
    model_reset(1'b1);
    m_ready_i   = 1'b1;
    csr_start_i = 1'b1;
    repeat (50) tick();
    csr_start_i = 1'b0;
    wait_hs(100, 100);
    csr_start_i = 1'b1;
    tick();
    csr_start_i = 1'b0;
    wait_done(100);
    chk("single_hs", hs_cnt, SPAN);
    chk("single_rd", rd_cnt, SPAN);
    repeat (5) tick();
    chk("single_idle", csr_busy_o, 0);

    // Asynchronous reset mid-run, then a clean pass.
    start_pass(1'b0);
    wait_hs(2000, 100);
    mon_en    = 1'b0;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
    start_pass(1'b0);
    wait_done(100);
    chk("post_rst_hs", hs_cnt, SPAN);
    chk("post_rst_rd", rd_cnt, SPAN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
